// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions: ALU operation classes, opcode constants and
// the ID/EX register update actions.
package id_ex_stage_pkg;

  // ALU operation class carried from decode into EX
  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  // RV32I major opcodes shared with the decode control unit
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // What the ID/EX register does on the next rising edge (reset aside)
  typedef enum logic [1:0] {
    ACT_HOLD       = 2'b00,
    ACT_FLUSH_BUB  = 2'b01,
    ACT_HAZARD_BUB = 2'b10,
    ACT_LOAD       = 2'b11
  } ex_action_e;

endpackage : id_ex_stage_pkg

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard comparator: the instruction in EX is a real load whose
// destination (non-x0) is read by the instruction currently in ID.
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic       ex_valid_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  output logic       hazard_o
);

  logic rd_nonzero;
  logic rd_match;

  // Purely combinational compare of the EX destination against ID sources
  always_comb begin
    rd_nonzero = (ex_rd_i != 5'd0);
    rd_match   = (ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i);
    hazard_o   = ex_valid_i & ex_memread_i & rd_nonzero & rd_match;
  end

endmodule : hazard_detect

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall hold, branch flush, load-use bubble
// insertion and a saturating count of load-use bubbles.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              ALUSrc_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [XLEN-1:0]   RS1data_i,
  input  logic [XLEN-1:0]   RS2data_i,
  input  logic [XLEN-1:0]   Imm_i,
  input  logic [9:0]        funct_i,
  input  logic [4:0]        RS1addr_i,
  input  logic [4:0]        RS2addr_i,
  input  logic [4:0]        RDaddr_i,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              ALUSrc_o,
  output logic [1:0]        ALUOp_o,
  output logic [XLEN-1:0]   RS1data_o,
  output logic [XLEN-1:0]   RS2data_o,
  output logic [XLEN-1:0]   Imm_o,
  output logic [9:0]        funct_o,
  output logic [4:0]        RS1addr_o,
  output logic [4:0]        RS2addr_o,
  output logic [4:0]        RDaddr_o,
  output logic              valid_o,
  output logic              hazard_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic              regwrite_q,  regwrite_d;
  logic              memtoreg_q,  memtoreg_d;
  logic              memread_q,   memread_d;
  logic              memwrite_q,  memwrite_d;
  logic              alusrc_q,    alusrc_d;
  logic [1:0]        aluop_q,     aluop_d;
  logic [XLEN-1:0]   rs1data_q,   rs1data_d;
  logic [XLEN-1:0]   rs2data_q,   rs2data_d;
  logic [XLEN-1:0]   imm_q,       imm_d;
  logic [9:0]        funct_q,     funct_d;
  logic [4:0]        rs1addr_q,   rs1addr_d;
  logic [4:0]        rs2addr_q,   rs2addr_d;
  logic [4:0]        rdaddr_q,    rdaddr_d;
  logic              valid_q,     valid_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic              hazard;
  ex_action_e        action;

  hazard_detect u_hazard_detect (
    .ex_valid_i   (valid_q),
    .ex_memread_i (memread_q),
    .ex_rd_i      (rdaddr_q),
    .id_rs1_i     (RS1addr_i),
    .id_rs2_i     (RS2addr_i),
    .hazard_o     (hazard)
  );

  // Edge action by priority: stall holds, flush beats hazard, else load
  always_comb begin
    action = ACT_LOAD;
    if (stall_i) begin
      action = ACT_HOLD;
    end else if (flush_i) begin
      action = ACT_FLUSH_BUB;
    end else if (hazard) begin
      action = ACT_HAZARD_BUB;
    end
  end

  // Next-state for the pipeline fields and the bubble counter
  always_comb begin
    regwrite_d   = regwrite_q;
    memtoreg_d   = memtoreg_q;
    memread_d    = memread_q;
    memwrite_d   = memwrite_q;
    alusrc_d     = alusrc_q;
    aluop_d      = aluop_q;
    rs1data_d    = rs1data_q;
    rs2data_d    = rs2data_q;
    imm_d        = imm_q;
    funct_d      = funct_q;
    rs1addr_d    = rs1addr_q;
    rs2addr_d    = rs2addr_q;
    rdaddr_d     = rdaddr_q;
    valid_d      = valid_q;
    bubble_cnt_d = bubble_cnt_q;

    unique case (action)
      ACT_HOLD: begin
      end
      ACT_FLUSH_BUB, ACT_HAZARD_BUB: begin
        regwrite_d = 1'b0;
        memtoreg_d = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        alusrc_d   = 1'b0;
        aluop_d    = ALUOP_MEM;
        rs1data_d  = '0;
        rs2data_d  = '0;
        imm_d      = '0;
        funct_d    = '0;
        rs1addr_d  = '0;
        rs2addr_d  = '0;
        rdaddr_d   = '0;
        valid_d    = 1'b0;
        if ((action == ACT_HAZARD_BUB) && (bubble_cnt_q != '1)) begin
          bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
      end
      ACT_LOAD: begin
        regwrite_d = RegWrite_i;
        memtoreg_d = MemtoReg_i;
        memread_d  = MemRead_i;
        memwrite_d = MemWrite_i;
        alusrc_d   = ALUSrc_i;
        aluop_d    = ALUOp_i;
        rs1data_d  = RS1data_i;
        rs2data_d  = RS2data_i;
        imm_d      = Imm_i;
        funct_d    = funct_i;
        rs1addr_d  = RS1addr_i;
        rs2addr_d  = RS2addr_i;
        rdaddr_d   = RDaddr_i;
        valid_d    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State registers with synchronous reset overriding stall and flush
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
      alusrc_q     <= 1'b0;
      aluop_q      <= '0;
      rs1data_q    <= '0;
      rs2data_q    <= '0;
      imm_q        <= '0;
      funct_q      <= '0;
      rs1addr_q    <= '0;
      rs2addr_q    <= '0;
      rdaddr_q     <= '0;
      valid_q      <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      regwrite_q   <= regwrite_d;
      memtoreg_q   <= memtoreg_d;
      memread_q    <= memread_d;
      memwrite_q   <= memwrite_d;
      alusrc_q     <= alusrc_d;
      aluop_q      <= aluop_d;
      rs1data_q    <= rs1data_d;
      rs2data_q    <= rs2data_d;
      imm_q        <= imm_d;
      funct_q      <= funct_d;
      rs1addr_q    <= rs1addr_d;
      rs2addr_q    <= rs2addr_d;
      rdaddr_q     <= rdaddr_d;
      valid_q      <= valid_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Register outputs and the combinational hazard flag
  always_comb begin
    RegWrite_o   = regwrite_q;
    MemtoReg_o   = memtoreg_q;
    MemRead_o    = memread_q;
    MemWrite_o   = memwrite_q;
    ALUSrc_o     = alusrc_q;
    ALUOp_o      = aluop_q;
    RS1data_o    = rs1data_q;
    RS2data_o    = rs2data_q;
    Imm_o        = imm_q;
    funct_o      = funct_q;
    RS1addr_o    = rs1addr_q;
    RS2addr_o    = rs2addr_q;
    RDaddr_o     = rdaddr_q;
    valid_o      = valid_q;
    hazard_o     = hazard;
    bubble_cnt_o = bubble_cnt_q;
  end

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a transaction-level model of the EX
// slot compared every cycle, plus directed scenarios with literal checks.
// The counter is built 8 bits wide so saturation is reachable quickly.
module tb_id_ex_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic            rw, m2r, mr, mw, as;
    logic [1:0]      aluop;
    logic [XLEN-1:0] d1, d2, imm;
    logic [9:0]      funct;
    logic [4:0]      rs1, rs2, rd;
    logic            valid;
  } slot_t;

  logic clk = 1'b0;
  logic rst_i = 1'b1, stall_i = 1'b0, flush_i = 1'b0;
  logic RegWrite_i = 0, MemtoReg_i = 0, MemRead_i = 0, MemWrite_i = 0, ALUSrc_i = 0;
  logic [1:0] ALUOp_i = '0;
  logic [XLEN-1:0] RS1data_i = '0, RS2data_i = '0, Imm_i = '0;
  logic [9:0] funct_i = '0;
  logic [4:0] RS1addr_i = '0, RS2addr_i = '0, RDaddr_i = '0;

  logic RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o;
  logic [1:0] ALUOp_o;
  logic [XLEN-1:0] RS1data_o, RS2data_o, Imm_o;
  logic [9:0] funct_o;
  logic [4:0] RS1addr_o, RS2addr_o, RDaddr_o;
  logic valid_o, hazard_o;
  logic [CNT_W-1:0] bubble_cnt_o;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  slot_t m = '0;
  int unsigned mcnt = 0;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i),
    .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i), .funct_i(funct_i),
    .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o), .ALUOp_o(ALUOp_o),
    .RS1data_o(RS1data_o), .RS2data_o(RS2data_o), .Imm_o(Imm_o), .funct_o(funct_o),
    .RS1addr_o(RS1addr_o), .RS2addr_o(RS2addr_o), .RDaddr_o(RDaddr_o),
    .valid_o(valid_o), .hazard_o(hazard_o), .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Load-use condition stated on the model's EX slot and the live ID inputs
  function automatic logic exp_hazard();
    return m.valid && m.mr && (m.rd != 5'd0) && (m.rd == RS1addr_i || m.rd == RS2addr_i);
  endfunction

  function automatic slot_t id_slot();
    slot_t s;
    s = '{rw: RegWrite_i, m2r: MemtoReg_i, mr: MemRead_i, mw: MemWrite_i, as: ALUSrc_i,
          aluop: ALUOp_i, d1: RS1data_i, d2: RS2data_i, imm: Imm_i, funct: funct_i,
          rs1: RS1addr_i, rs2: RS2addr_i, rd: RDaddr_i, valid: 1'b1};
    return s;
  endfunction

  // Reference model: what the EX slot holds after each edge
  always @(posedge clk) begin
    if (rst_i) begin
      m <= '0;
      mcnt <= 0;
    end else if (!stall_i) begin
      if (flush_i) begin
        m <= '0;
      end else if (exp_hazard()) begin
        m <= '0;
        mcnt <= (mcnt == CMAX) ? CMAX : mcnt + 1;
      end else begin
        m <= id_slot();
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("RegWrite", 64'(RegWrite_o), 64'(m.rw));
      check("MemtoReg", 64'(MemtoReg_o), 64'(m.m2r));
      check("MemRead",  64'(MemRead_o),  64'(m.mr));
      check("MemWrite", 64'(MemWrite_o), 64'(m.mw));
      check("ALUSrc",   64'(ALUSrc_o),   64'(m.as));
      check("ALUOp",    64'(ALUOp_o),    64'(m.aluop));
      check("RS1data",  64'(RS1data_o),  64'(m.d1));
      check("RS2data",  64'(RS2data_o),  64'(m.d2));
      check("Imm",      64'(Imm_o),      64'(m.imm));
      check("funct",    64'(funct_o),    64'(m.funct));
      check("RS1addr",  64'(RS1addr_o),  64'(m.rs1));
      check("RS2addr",  64'(RS2addr_o),  64'(m.rs2));
      check("RDaddr",   64'(RDaddr_o),   64'(m.rd));
      check("valid",    64'(valid_o),    64'(m.valid));
      check("hazard",   64'(hazard_o),   64'(exp_hazard()));
      check("bubble_cnt", 64'(bubble_cnt_o), 64'(mcnt));
    end
  end

  // Advance one cycle; returns just after the negedge compare
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ctrl = {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc}
  task automatic set_id(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] ctrl, input logic [1:0] aluop,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [9:0] f);
    {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i} = ctrl;
    ALUOp_i = aluop; RS1data_i = d1; RS2data_i = d2; Imm_i = imm; funct_i = f;
    RDaddr_i = rd; RS1addr_i = rs1; RS2addr_i = rs2;
  endtask

  task automatic set_lw(input logic [4:0] rd);
    set_id(rd, 5'd1, 5'd0, 5'b11101, 2'b00, 32'd100, 32'd0, 32'd8, 10'b0000000_010);
  endtask

  task automatic set_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    set_id(rd, rs1, rs2, 5'b10000, 2'b10, 32'd11, 32'd22, 32'd0, 10'd0);
  endtask

  task automatic randomize_id(input int unsigned addr_range);
    {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i} = 5'($urandom);
    ALUOp_i = 2'($urandom);
    RS1data_i = $urandom; RS2data_i = $urandom; Imm_i = $urandom;
    funct_i = 10'($urandom);
    RS1addr_i = 5'($urandom_range(addr_range));
    RS2addr_i = 5'($urandom_range(addr_range));
    RDaddr_i  = 5'($urandom_range(addr_range));
  endtask

  initial begin
    // Reset for two cycles with random inputs, stall and flush
    rst_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      randomize_id(31);
      stall_i = 1'($urandom); flush_i = 1'($urandom);
      tick();
      chk_en = 1'b1;
    end
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_cnt", 64'(bubble_cnt_o), 64'd0);
    check("rst_rs1data", 64'(RS1data_o), 64'd0);
    check("rst_regwrite", 64'(RegWrite_o), 64'd0);
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;

    // add x3,x1,x2 passes through in one cycle
    set_id(5'd3, 5'd1, 5'd2, 5'b10000, 2'b10, 32'd5, 32'd7, 32'd0, 10'd0);
    tick();
    check("add_rs1data", 64'(RS1data_o), 64'd5);
    check("add_rs2data", 64'(RS2data_o), 64'd7);
    check("add_rd", 64'(RDaddr_o), 64'd3);
    check("add_aluop", 64'(ALUOp_o), 64'b10);
    check("add_valid", 64'(valid_o), 64'd1);
    check("add_hazard", 64'(hazard_o), 64'd0);

    // lw x5 in EX, ID reads x5 -> one counted bubble
    set_lw(5'd5); tick();
    set_add(5'd6, 5'd5, 5'd2); #1;
    check("lu_hazard", 64'(hazard_o), 64'd1);
    tick();
    check("lu_valid", 64'(valid_o), 64'd0);
    check("lu_regwrite", 64'(RegWrite_o), 64'd0);
    check("lu_memread", 64'(MemRead_o), 64'd0);
    check("lu_cnt", 64'(bubble_cnt_o), 64'd1);
    check("lu_hazard_after", 64'(hazard_o), 64'd0);
    tick();
    check("lu_reload_rd", 64'(RDaddr_o), 64'd6);

    // lw x0 never raises a hazard
    set_lw(5'd0); tick();
    set_add(5'd7, 5'd0, 5'd0); #1;
    check("x0_hazard", 64'(hazard_o), 64'd0);
    tick();
    check("x0_rd", 64'(RDaddr_o), 64'd7);
    check("x0_valid", 64'(valid_o), 64'd1);

    // stall beats flush; flush bubble after release is not counted
    set_add(5'd9, 5'd1, 5'd2); tick();
    stall_i = 1'b1; flush_i = 1'b1; set_add(5'd10, 5'd3, 5'd4);
    for (int i = 0; i < 3; i++) tick();
    check("stall_rd", 64'(RDaddr_o), 64'd9);
    check("stall_valid", 64'(valid_o), 64'd1);
    stall_i = 1'b0; tick();
    check("flush_valid", 64'(valid_o), 64'd0);
    check("flush_cnt", 64'(bubble_cnt_o), 64'd1);
    flush_i = 1'b0;

    // flush and hazard together: one bubble, counted as flush
    set_lw(5'd5); tick();
    set_add(5'd6, 5'd5, 5'd0); flush_i = 1'b1; #1;
    check("fh_hazard", 64'(hazard_o), 64'd1);
    tick();
    check("fh_valid", 64'(valid_o), 64'd0);
    check("fh_cnt", 64'(bubble_cnt_o), 64'd1);
    flush_i = 1'b0;

    // hazard visible under stall but without effect until release
    set_lw(5'd5); tick();
    set_add(5'd6, 5'd5, 5'd5); stall_i = 1'b1;
    tick(); tick();
    check("sh_hazard", 64'(hazard_o), 64'd1);
    check("sh_rd", 64'(RDaddr_o), 64'd5);
    check("sh_cnt", 64'(bubble_cnt_o), 64'd1);
    stall_i = 1'b0; tick();
    check("sh_valid", 64'(valid_o), 64'd0);
    check("sh_cnt_after", 64'(bubble_cnt_o), 64'd2);

    // reset asserted mid-hazard drops hazard_o
    set_lw(5'd5); tick();
    set_add(5'd6, 5'd5, 5'd2); #1;
    check("rh_hazard", 64'(hazard_o), 64'd1);
    rst_i = 1'b1; tick();
    check("rh_hazard_after", 64'(hazard_o), 64'd0);
    check("rh_cnt", 64'(bubble_cnt_o), 64'd0);
    rst_i = 1'b0;

    // saturation: CMAX hazards fill the counter, one more keeps it
    for (int unsigned i = 0; i < CMAX; i++) begin
      set_lw(5'd5); tick();
      set_add(5'd6, 5'd5, 5'd2); tick();
    end
    check("sat_full", 64'(bubble_cnt_o), 64'(CMAX));
    set_lw(5'd5); tick();
    set_add(5'd6, 5'd5, 5'd2); tick();
    check("sat_hold", 64'(bubble_cnt_o), 64'(CMAX));
    check("sat_bubble", 64'(valid_o), 64'd0);

    // random traffic with narrow register range to provoke hazards
    for (int i = 0; i < 300; i++) begin
      randomize_id(3);
      stall_i = ($urandom_range(5) == 0);
      flush_i = ($urandom_range(7) == 0);
      rst_i   = ($urandom_range(99) == 0);
      tick();
    end
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_id_ex_stage

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: XLEN, 32, width of the register-data and immediate paths.
REQ-002 Parameter: CNT_W, 16, width of the load-use bubble counter.
REQ-003 clk_i  input  1  single clock, all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 stall_i  input  1  global freeze (memory wait), holds every register.
REQ-006 flush_i  input  1  taken branch in ID, squashes the instruction being latched.
REQ-007 RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i  input  1 each  decoded control from the decode control unit.
REQ-008 ALUOp_i  input  2  ALU operation class (00 mem, 10 R-type, 11 I-type).
REQ-009 RS1data_i, RS2data_i, Imm_i  input  XLEN each  register-file read data and sign-extended immediate.
REQ-010 funct_i  input  10  {funct7, funct3} of the ID instruction.
REQ-011 RS1addr_i, RS2addr_i, RDaddr_i  input  5 each  ID source and destination register numbers.
REQ-012 Each latched input has a matching _o output of equal width, plus valid_o (1 bit, EX slot holds a real instruction).
REQ-013 hazard_o  output  1  load-use hazard; upstream holds PC and IF/ID while high.
REQ-014 bubble_cnt_o  output  CNT_W  count of load-use bubbles inserted.

Function
REQ-015 hazard_o SHALL be combinational: valid_o & MemRead_o & (RDaddr_o != 0) & (RDaddr_o == RS1addr_i | RDaddr_o == RS2addr_i).
REQ-016 Per-edge priority SHALL be: rst_i, then stall_i (hold all), then flush_i (bubble), then hazard_o (bubble), else load.
REQ-017 Load SHALL copy every _i field to its _o register and set valid_o=1; latency exactly one cycle.
REQ-018 Bubble SHALL clear every control output, ALUOp_o, valid_o, data, funct and address outputs to 0.
REQ-019 During stall_i, hazard_o SHALL still be evaluated but have no effect on state; bubble_cnt_o holds.
REQ-020 bubble_cnt_o SHALL increment by 1 only on a hazard bubble (not a flush bubble), saturating at all-ones.
REQ-021 flush_i and hazard_o in the same cycle SHALL produce one bubble, counted as flush (no increment).
REQ-022 Upstream keeps flush_i asserted across stall cycles; the block does not remember a flush seen under stall_i.
REQ-023 A load whose RDaddr is x0 SHALL never raise hazard_o.
REQ-024 The bubble inserted for a hazard SHALL clear hazard_o next cycle (valid_o=0), releasing upstream after exactly one stall cycle.

Reset
REQ-025 With rst_i high at an edge, all outputs SHALL become 0, including valid_o and bubble_cnt_o, regardless of stall_i or flush_i.
REQ-026 After reset release, the first load SHALL occur on the first edge with rst_i=0 and stall_i=0.
REQ-027 Reset asserted mid-hazard SHALL drop hazard_o combinationally in the following cycle since valid_o=0.

Structure
REQ-028 ALUOp encodings (ALUOP_MEM=00, ALUOP_R=10, ALUOP_I=11) and the opcode constants shared with the control unit SHALL live in the shared pipeline package.
REQ-029 The load-use comparator SHALL be a sub-module hazard_detect (purely combinational); all registers remain in id_ex_stage.

Verification
REQ-030 Reset: rst_i=1 for 2 cycles with random inputs -> all outputs 0, bubble_cnt_o=0.
REQ-031 Pass-through: add x3,x1,x2 (RegWrite=1, ALUOp=10, RS1data=5, RS2data=7) -> next cycle outputs equal inputs, valid_o=1, hazard_o=0.
REQ-032 Load-use: lw x5 in EX, ID RS1addr=5 -> hazard_o=1, next edge bubble (all controls 0), bubble_cnt_o=1, hazard_o=0 after.
REQ-033 x0 load: lw x0 in EX, ID RS2addr=0 -> hazard_o=0, normal load.
REQ-034 Stall priority: stall_i=1 with flush_i=1 for 3 cycles -> outputs frozen; first edge with stall_i=0 -> bubble.
REQ-035 Saturation: preload counter to 16'hFFFF via 65535 hazards -> next hazard keeps bubble_cnt_o=16'hFFFF.
